// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared widths, reset PC default and fetch-unit state encoding.
// Imported by the fetch unit top and its FIFO.
package ysyx_22040365_ifu_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ibuf_ent_t;

endpackage

// File: rtl/ysyx_22040365_ifu_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage (no added latency).
// Push on a full FIFO is only accepted when a pop happens in the same cycle.
module ysyx_22040365_ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             empty, full, do_push, do_pop;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_q - rd_q;
    assign head_dat = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && full && !pop));

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch: owns the PC, issues word reads, buffers {inst, pc} for decode.
// Redirect squashes buffered and in-flight fetches; faults halt fetching until redirected.
module ysyx_22040365_ifu
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    ifu_state_e   state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic         err_q, err_d;

    logic [CW-1:0] ibuf_cnt, tag_cnt;
    logic [CW:0]   occ;
    ibuf_ent_t     ibuf_in, ibuf_head;
    logic [63:0]   tag_head;
    logic          req_fire, resp_live, resp_drop, ibuf_push, halted;

    // The tag queue holds exactly the live outstanding requests.
    assign occ            = {1'b0, tag_cnt} + {1'b0, ibuf_cnt};
    assign halted         = (state_q == ST_HALT);
    assign imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid && (occ < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_q != '0);
    assign resp_live      = imem_resp_valid && (drop_q == '0);
    assign ibuf_push      = resp_live && !imem_resp_err && !halted;
    assign ibuf_in        = '{inst: imem_resp_data, pc: tag_head};

    assign inst_valid = (ibuf_cnt != '0);
    assign inst       = inst_valid ? ibuf_head.inst : '0;
    assign inst_pc    = inst_valid ? ibuf_head.pc   : '0;
    assign fetch_err  = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        err_d   = err_q;
        if (redirect_valid) begin
            drop_d = drop_q + tag_cnt + CW'(req_fire) - CW'(imem_resp_valid);
            pc_d   = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end else begin
                err_d   = 1'b0;
                state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            end
        end else begin
            if (req_fire)  pc_d   = pc_q + 64'd4;
            if (resp_drop) drop_d = drop_q - 1'b1;
            if (resp_live && imem_resp_err && !halted) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end else if (state_q == ST_DRAIN && drop_d == '0) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    ysyx_22040365_ifu_fifo #(.WIDTH($bits(ibuf_ent_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (ibuf_push),
        .push_dat (ibuf_in),
        .pop      (inst_valid && inst_ready),
        .head_dat (ibuf_head),
        .count    (ibuf_cnt)
    );

    ysyx_22040365_ifu_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_tagq (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (req_fire),
        .push_dat (pc_q),
        .pop      (resp_live),
        .head_dat (tag_head),
        .count    (tag_cnt)
    );

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Bench for the fetch unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ysyx_22040365_ifu;
    import ysyx_22040365_ifu_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_err;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_err;

    ysyx_22040365_ifu #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Stimulus knobs
    bit          rst_in, mem_rdy, dec_rdy, redir;
    logic [63:0] redir_pc;
    int          lat, err_at, resp_idx, cyc, c0, first_iv, fires;
    bit          seen_drain;

    // Memory model: in-order responses, each due `lat` cycles after acceptance
    typedef struct { logic [63:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    // Reference model: in-flight fetches (live or squashed) and the decode buffer
    typedef struct { logic [63:0] pc; bit live; } fl_t;
    typedef struct { logic [31:0] inst; logic [63:0] pc; } be_t;
    fl_t  infl[$];
    be_t  mbuf[$];
    logic [63:0] m_pc;
    bit   m_err, m_halt, m_init;

    logic [63:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int n_dead();
        int n = 0;
        foreach (infl[i]) if (!infl[i].live) n++;
        return n;
    endfunction

    function automatic bit model_req();
        return !rst_in && !m_halt && (n_dead() == 0) && !redir &&
               (infl.size() + mbuf.size() < DEPTH);
    endfunction

    task automatic compare();
        ifu_state_e es;
        bit erv;
        erv = model_req();
        chk("req_valid", 64'(imem_req_valid), 64'(erv));
        if (erv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 64'(inst_valid), 64'(mbuf.size() > 0));
        chk("inst", 64'(inst), (mbuf.size() > 0) ? 64'(mbuf[0].inst) : 64'd0);
        chk("inst_pc", inst_pc, (mbuf.size() > 0) ? mbuf[0].pc : 64'd0);
        chk("fetch_err", 64'(fetch_err), 64'(m_err));
        es = m_halt ? ST_HALT : ((n_dead() > 0) ? ST_DRAIN : ST_RUN);
        chk("state", 64'(dut.state_q), 64'(es));
    endtask

    task automatic tick();
        bit rv, rerr, m_fire, m_pop;
        logic [31:0] rd;
        fl_t f;
        @(negedge clk);
        rv = 1'b0; rerr = 1'b0; rd = '0;
        if (!rst_in && mq.size() > 0 && mq[0].due <= cyc) begin
            rv   = 1'b1;
            rd   = mq[0].addr[31:0];
            rerr = (resp_idx == err_at);
        end
        rst = rst_in; imem_req_ready = mem_rdy;
        imem_resp_valid = rv; imem_resp_data = rd; imem_resp_err = rerr;
        inst_ready = dec_rdy; redirect_valid = redir; redirect_pc = redir_pc;
        #1;
        if (m_init) compare();
        if (!rst_in && inst_valid && first_iv < 0) first_iv = cyc - c0;
        if (dut.state_q == ST_DRAIN) seen_drain = 1'b1;
        if (inst_valid && inst_ready && !rst_in) begin
            dlv_pc.push_back(inst_pc);
            dlv_inst.push_back(inst);
        end
        if (imem_req_valid && imem_req_ready && !rst_in) begin
            fires++;
            mq.push_back('{imem_req_addr, cyc + lat});
        end
        if (rv) begin
            void'(mq.pop_front());
            resp_idx++;
        end
        m_fire = model_req() && mem_rdy;
        m_pop  = (mbuf.size() > 0) && dec_rdy;
        if (rst_in) begin
            mq.delete(); infl.delete(); mbuf.delete();
            resp_idx = 0; m_pc = RPC; m_err = 0; m_halt = 0; m_init = 1;
        end else begin
            if (m_pop) void'(mbuf.pop_front());
            if (rv && infl.size() > 0) begin
                f = infl.pop_front();
                if (f.live && !m_halt) begin
                    if (rerr) begin m_err = 1; m_halt = 1; end
                    else mbuf.push_back('{rd, f.pc});
                end
            end
            if (m_fire) begin
                infl.push_back('{m_pc, 1'b1});
                m_pc = m_pc + 64'd4;
            end
            if (redir) begin
                mbuf.delete();
                foreach (infl[i]) infl[i].live = 1'b0;
                m_pc = redir_pc;
                if (redir_pc[1:0] != 2'b00) begin m_err = 1; m_halt = 1; end
                else begin m_err = 0; m_halt = 0; end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_in = 1; redir = 0; mem_rdy = 1; err_at = -1;
        tick(); tick();
        rst_in = 0; c0 = cyc; first_iv = -1; fires = 0; seen_drain = 0;
        dlv_pc.delete(); dlv_inst.delete();
    endtask

    task automatic redirect_to(input logic [63:0] target);
        redir = 1; redir_pc = target;
        tick();
        redir = 0;
    endtask

    initial begin
        int n0, f0;
        cyc = 0; m_init = 0; resp_idx = 0; lat = 1; dec_rdy = 0; redir_pc = '0;

        // Decode stalled after reset, then released
        lat = 1; dec_rdy = 0;
        do_reset();
        repeat (10) tick();
        chk("stall_fires", 64'(fires), 64'd2);
        chk("first_valid_delay", 64'(first_iv), 64'd2);
        dec_rdy = 1;
        repeat (8) tick();
        chk("stream_len_ge3", 64'(dlv_pc.size() >= 3), 64'd1);
        if (dlv_pc.size() >= 3) begin
            chk("stream_pc0", dlv_pc[0], 64'h8000_0000);
            chk("stream_pc1", dlv_pc[1], 64'h8000_0004);
            chk("stream_pc2", dlv_pc[2], 64'h8000_0008);
            chk("stream_inst2", 64'(dlv_inst[2]), 64'h8000_0008);
        end

        // Redirect with two requests in flight
        lat = 3;
        do_reset();
        tick(); tick();
        chk("inflight_before_redirect", 64'(fires), 64'd2);
        redirect_to(64'h8000_0100);
        repeat (10) tick();
        chk("drain_seen", 64'(seen_drain), 64'd1);
        chk("redir_first_valid", 64'(dlv_pc.size() > 0), 64'd1);
        if (dlv_pc.size() > 0) chk("redir_first_pc", dlv_pc[0], 64'h8000_0100);

        // Redirect in a cycle carrying a response
        lat = 2;
        do_reset();
        repeat (6) tick();
        for (int i = 0; i < 10 && !(mq.size() > 0 && mq[0].due <= cyc); i++) tick();
        redirect_to(64'h8000_0300);
        n0 = dlv_pc.size();
        repeat (10) tick();
        chk("redir_resp_valid", 64'(dlv_pc.size() > n0), 64'd1);
        if (dlv_pc.size() > n0) chk("redir_resp_pc", dlv_pc[n0], 64'h8000_0300);

        // Access fault on the third response
        lat = 1;
        do_reset();
        err_at = 2;
        repeat (12) tick();
        chk("fault_err", 64'(fetch_err), 64'd1);
        chk("fault_dlv_cnt", 64'(dlv_pc.size()), 64'd2);
        chk("fault_fires", 64'(fires), 64'd4);
        if (dlv_pc.size() >= 2) begin
            chk("fault_pc0", dlv_pc[0], 64'h8000_0000);
            chk("fault_pc1", dlv_pc[1], 64'h8000_0004);
        end
        err_at = -1;
        redirect_to(64'h8000_0200);
        repeat (8) tick();
        chk("recover_err", 64'(fetch_err), 64'd0);
        chk("recover_dlv", 64'(dlv_pc.size() >= 3), 64'd1);
        if (dlv_pc.size() >= 3) chk("recover_pc", dlv_pc[2], 64'h8000_0200);

        // Misaligned redirect
        redirect_to(64'h8000_0202);
        f0 = fires;
        repeat (6) tick();
        chk("misalign_err", 64'(fetch_err), 64'd1);
        chk("misalign_no_req", 64'(fires - f0), 64'd0);
        chk("misalign_state", 64'(dut.state_q), 64'(ST_HALT));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
